// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared frontend definitions: fetch geometry, sequencer states and the
// ibuffer entry layout used by every fetch-side block.
package ifu_fetch_ctrl_pkg;

  localparam int unsigned FETCH_WIDTH = 4;
  localparam int unsigned FETCH_BYTES = 16;
  localparam int unsigned SLOT_BITS   = 32;
  localparam int unsigned SLOT_IDX_W  = $clog2(FETCH_WIDTH);
  localparam int unsigned SLOT_CNT_W  = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned GROUP_BITS  = FETCH_WIDTH * SLOT_BITS;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DRAIN
  } fetch_state_e;

  // One ibuffer entry is 129 bits: {target[31:0], taken, pc[63:0], instr[31:0]}
  localparam int unsigned GRP_INSTR_LSB  = 0;
  localparam int unsigned GRP_INSTR_W    = 32;
  localparam int unsigned GRP_PC_LSB     = GRP_INSTR_LSB + GRP_INSTR_W;
  localparam int unsigned GRP_PC_W       = 64;
  localparam int unsigned GRP_TAKEN_BIT  = GRP_PC_LSB + GRP_PC_W;
  localparam int unsigned GRP_TARGET_LSB = GRP_TAKEN_BIT + 1;
  localparam int unsigned GRP_TARGET_W   = 32;
  localparam int unsigned GRP_ENTRY_W    = GRP_TARGET_LSB + GRP_TARGET_W;

  // Number of set bits in a slot mask
  function automatic logic [SLOT_CNT_W-1:0] slot_popcount(input logic [FETCH_WIDTH-1:0] m);
    logic [SLOT_CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      n = n + SLOT_CNT_W'(m[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_group_decode.sv
// Combinational group decode: masks slots ahead of the fetch offset and past
// the first predicted-taken slot, and picks the following fetch PC.
module fetch_group_decode
  import ifu_fetch_ctrl_pkg::*;
(
  input  logic [63:4]             pc_line,
  input  logic [SLOT_IDX_W-1:0]   pc_slot,
  input  logic [FETCH_WIDTH-1:0]  taken,
  input  logic [GROUP_BITS-1:0]   target,
  output logic [FETCH_WIDTH-1:0]  mask,
  output logic [FETCH_WIDTH-1:0]  taken_masked,
  output logic [63:0]             next_pc,
  output logic [SLOT_CNT_W-1:0]   count
);

  logic                  hit;
  logic [SLOT_IDX_W-1:0] hit_idx;

  // Walk slots from the fetch offset, stopping after the first taken slot
  always_comb begin
    mask    = '0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if ((i >= 32'(pc_slot)) && !hit) begin
        mask[i] = 1'b1;
        if (taken[i]) begin
          hit     = 1'b1;
          hit_idx = i[SLOT_IDX_W-1:0];
        end
      end
    end
    taken_masked = taken & mask;
    count        = slot_popcount(mask);
    if (hit) begin
      next_pc = {32'b0, target[hit_idx*SLOT_BITS +: SLOT_BITS]};
    end else begin
      next_pc = {pc_line + 60'd1, 4'b0};
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one group request at a time to
// the icache arbiter, masks returned groups and hands them to the ibuffer
// under a free-entry credit budget.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned IB_DEPTH = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    redirect_valid,
  input  logic [63:0]             redirect_target,
  output logic                    fetch_req_valid,
  input  logic                    fetch_req_ready,
  output logic [63:0]             fetch_req_pc,
  input  logic                    fetch_resp_valid,
  input  logic [GROUP_BITS-1:0]   fetch_resp_instr,
  input  logic [FETCH_WIDTH-1:0]  fetch_resp_taken,
  input  logic [GROUP_BITS-1:0]   fetch_resp_target,
  output logic [FETCH_WIDTH-1:0]  ib_instr_valid,
  output logic [GROUP_BITS-1:0]   ib_instr,
  output logic [FETCH_WIDTH-1:0]  ib_predicttaken,
  output logic [GROUP_BITS-1:0]   ib_predicttarget,
  output logic [63:0]             ib_pc,
  input  logic                    ib_pop,
  output logic                    busy
);

  localparam int unsigned    CW          = $clog2(IB_DEPTH + 1);
  localparam logic [CW-1:0]  CREDIT_FULL = CW'(IB_DEPTH);
  localparam logic [CW-1:0]  GROUP_COST  = CW'(FETCH_WIDTH);

  fetch_state_e            state_q, state_d;
  logic [63:0]             pc_q, pc_d;
  logic [CW-1:0]           credits_q, credits_d;
  logic                    req_valid_q, req_valid_d;
  logic [FETCH_WIDTH-1:0]  ib_valid_q, ib_valid_d;
  logic [GROUP_BITS-1:0]   ib_instr_q, ib_instr_d;
  logic [FETCH_WIDTH-1:0]  ib_taken_q, ib_taken_d;
  logic [GROUP_BITS-1:0]   ib_target_q, ib_target_d;
  logic [63:0]             ib_pc_q, ib_pc_d;

  logic [FETCH_WIDTH-1:0]  dec_mask;
  logic [FETCH_WIDTH-1:0]  dec_taken;
  logic [63:0]             dec_next_pc;
  logic [SLOT_CNT_W-1:0]   dec_count;

  logic                    handshake;
  logic                    deliver;
  logic                    outstanding;
  logic [CW:0]             credit_sum;

  fetch_group_decode u_decode (
    .pc_line      (pc_q[63:4]),
    .pc_slot      (pc_q[3:2]),
    .taken        (fetch_resp_taken),
    .target       (fetch_resp_target),
    .mask         (dec_mask),
    .taken_masked (dec_taken),
    .next_pc      (dec_next_pc),
    .count        (dec_count)
  );

  // Next-state, PC, credit and delivery logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ib_valid_d  = '0;
    ib_instr_d  = ib_instr_q;
    ib_taken_d  = ib_taken_q;
    ib_target_d = ib_target_q;
    ib_pc_d     = ib_pc_q;

    handshake = req_valid_q && fetch_req_ready;
    deliver   = (state_q == WAIT) && fetch_resp_valid && !redirect_valid;

    unique case (state_q)
      REQ: begin
        if (handshake) state_d = WAIT;
      end
      WAIT: begin
        if (fetch_resp_valid) begin
          state_d = REQ;
          pc_d    = dec_next_pc;
        end
      end
      DRAIN: begin
        if (fetch_resp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    if (deliver) begin
      ib_valid_d  = dec_mask;
      ib_instr_d  = fetch_resp_instr;
      ib_taken_d  = dec_taken;
      ib_target_d = fetch_resp_target;
      ib_pc_d     = pc_q;
    end

    credit_sum = (CW+1)'(credits_q)
               - (deliver ? (CW+1)'(dec_count) : '0)
               + (CW+1)'(ib_pop);
    if (credit_sum > (CW+1)'(CREDIT_FULL)) begin
      credits_d = CREDIT_FULL;
    end else begin
      credits_d = credit_sum[CW-1:0];
    end

    // A response landing in the redirect cycle retires the outstanding
    // request, so only an unanswered request forces a drain.
    outstanding = (((state_q == WAIT) || (state_q == DRAIN)) && !fetch_resp_valid)
                || ((state_q == REQ) && handshake);
    if (redirect_valid) begin
      pc_d       = redirect_target;
      credits_d  = CREDIT_FULL;
      ib_valid_d = '0;
      state_d    = outstanding ? DRAIN : REQ;
    end

    req_valid_d = (state_d == REQ) && (credits_d >= GROUP_COST);
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch PC, credit and request-valid registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      credits_q   <= CREDIT_FULL;
      req_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      credits_q   <= credits_d;
      req_valid_q <= req_valid_d;
    end
  end

  // Registered ibuffer delivery
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ib_valid_q  <= '0;
      ib_instr_q  <= '0;
      ib_taken_q  <= '0;
      ib_target_q <= '0;
      ib_pc_q     <= '0;
    end else begin
      ib_valid_q  <= ib_valid_d;
      ib_instr_q  <= ib_instr_d;
      ib_taken_q  <= ib_taken_d;
      ib_target_q <= ib_target_d;
      ib_pc_q     <= ib_pc_d;
    end
  end

  // Output drive; a redirect suppresses the group presented in its own cycle
  always_comb begin
    fetch_req_valid  = req_valid_q;
    fetch_req_pc     = req_valid_q ? pc_q : '0;
    ib_instr_valid   = ib_valid_q & {FETCH_WIDTH{~redirect_valid}};
    ib_instr         = ib_instr_q;
    ib_predicttaken  = ib_taken_q;
    ib_predicttarget = ib_target_q;
    ib_pc            = ib_pc_q;
    busy             = (state_q != REQ) || req_valid_q;
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench for ifu_fetch_ctrl: directed fetch traffic, expected
// requests and ibuffer groups queued at issue and checked by a monitor.
module tb_ifu_fetch_ctrl;

  logic         clock;
  logic         reset_n;
  logic         redirect_valid;
  logic [63:0]  redirect_target;
  logic         fetch_req_valid;
  logic         fetch_req_ready;
  logic [63:0]  fetch_req_pc;
  logic         fetch_resp_valid;
  logic [127:0] fetch_resp_instr;
  logic [3:0]   fetch_resp_taken;
  logic [127:0] fetch_resp_target;
  logic [3:0]   ib_instr_valid;
  logic [127:0] ib_instr;
  logic [3:0]   ib_predicttaken;
  logic [127:0] ib_predicttarget;
  logic [63:0]  ib_pc;
  logic         ib_pop;
  logic         busy;

  typedef struct {
    logic [63:0]  pc;
    logic [3:0]   mask;
    logic [3:0]   taken;
    logic [127:0] instr;
    logic [127:0] tgt;
  } ib_exp_t;

  logic [63:0] req_q[$];
  ib_exp_t     ib_q[$];
  int          tests = 0;
  int          fails = 0;

  ifu_fetch_ctrl #(.RESET_PC(64'h8000_0000), .IB_DEPTH(16)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .fetch_req_valid   (fetch_req_valid),
    .fetch_req_ready   (fetch_req_ready),
    .fetch_req_pc      (fetch_req_pc),
    .fetch_resp_valid  (fetch_resp_valid),
    .fetch_resp_instr  (fetch_resp_instr),
    .fetch_resp_taken  (fetch_resp_taken),
    .fetch_resp_target (fetch_resp_target),
    .ib_instr_valid    (ib_instr_valid),
    .ib_instr          (ib_instr),
    .ib_predicttaken   (ib_predicttaken),
    .ib_predicttarget  (ib_predicttarget),
    .ib_pc             (ib_pc),
    .ib_pop            (ib_pop),
    .busy              (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted request and every delivered group is matched
  // against the oldest queued expectation
  always @(negedge clock) begin
    if (reset_n) begin
      if (fetch_req_valid && fetch_req_ready) begin
        if (req_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_req: got pc %h expected no request", fetch_req_pc);
        end else begin
          check("req_pc", 128'(fetch_req_pc), 128'(req_q.pop_front()));
        end
      end
      if (ib_instr_valid != 4'b0) begin
        if (ib_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ib: got mask %b pc %h expected no delivery", ib_instr_valid, ib_pc);
        end else begin
          ib_exp_t e;
          e = ib_q.pop_front();
          check("ib_mask",   128'(ib_instr_valid),  128'(e.mask));
          check("ib_pc",     128'(ib_pc),           128'(e.pc));
          check("ib_taken",  128'(ib_predicttaken), 128'(e.taken));
          check("ib_instr",  ib_instr,              e.instr);
          check("ib_target", ib_predicttarget,      e.tgt);
        end
      end
    end
  end

  task automatic wait_req(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (fetch_req_valid) return;
    end
    tests++; fails++;
    $display("FAIL req_timeout: got fetch_req_valid 0 expected 1 within %0d cycles", budget);
  endtask

  task automatic accept_req();
    wait_req(20);
    fetch_req_ready = 1'b1;
    @(posedge clock); #1;
    fetch_req_ready = 1'b0;
  endtask

  // One full request/response exchange with a 1-cycle icache
  task automatic fetch_group(input logic [63:0] pc, input logic [3:0] taken,
                             input logic [127:0] tgt, input logic [127:0] instr,
                             input logic [3:0] exp_mask, input logic [3:0] exp_taken);
    ib_exp_t e;
    e.pc = pc; e.mask = exp_mask; e.taken = exp_taken; e.instr = instr; e.tgt = tgt;
    req_q.push_back(pc);
    ib_q.push_back(e);
    accept_req();
    fetch_resp_valid  = 1'b1;
    fetch_resp_instr  = instr;
    fetch_resp_taken  = taken;
    fetch_resp_target = tgt;
    @(posedge clock); #1;
    fetch_resp_valid  = 1'b0;
    fetch_resp_taken  = 4'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_valid"}, 128'(fetch_req_valid),  128'(0));
    check({tag, "_req_pc"},    128'(fetch_req_pc),     128'(0));
    check({tag, "_ib_valid"},  128'(ib_instr_valid),   128'(0));
    check({tag, "_ib_instr"},  ib_instr,               128'(0));
    check({tag, "_ib_taken"},  128'(ib_predicttaken),  128'(0));
    check({tag, "_ib_target"}, ib_predicttarget,       128'(0));
    check({tag, "_ib_pc"},     128'(ib_pc),            128'(0));
    check({tag, "_busy"},      128'(busy),             128'(0));
  endtask

  localparam logic [127:0] NO_TGT  = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
  localparam logic [127:0] TK_TGT  = {32'hAAAA_0003, 32'hAAAA_0002, 32'h8000_0400, 32'hAAAA_0000};

  initial begin
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    fetch_req_ready = 1'b0;
    fetch_resp_valid = 1'b0;
    fetch_resp_instr = '0;
    fetch_resp_taken = '0;
    fetch_resp_target = '0;
    ib_pop = 1'b0;
    #3;
    check_outputs_zero("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Sequential groups until the 16 credits are used up
    for (int unsigned g = 0; g < 4; g++) begin
      logic [63:0] p;
      p = 64'h8000_0000 + 64'(g * 16);
      fetch_group(p, 4'b0, NO_TGT, {4{32'h1100_0000 + 32'(g)}}, 4'b1111, 4'b0);
    end
    repeat (3) begin
      @(posedge clock); #1;
      check("no_credit_block", 128'(fetch_req_valid), 128'(0));
    end
    ib_pop = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("three_pops_block", 128'(fetch_req_valid), 128'(0));
    @(posedge clock); #1;
    ib_pop = 1'b0;
    check("four_pops_valid", 128'(fetch_req_valid), 128'(1));
    check("four_pops_pc",    128'(fetch_req_pc),    128'(64'h8000_0040));

    // Redirect while a request is presented but not accepted
    redirect_valid = 1'b1;
    redirect_target = 64'h8000_0108;
    @(posedge clock); #1;
    redirect_valid = 1'b0;
    fetch_group(64'h8000_0108, 4'b0, NO_TGT, {4{32'h2200_0001}}, 4'b1100, 4'b0);
    // Taken slot 1 truncates the group and steers to its target
    fetch_group(64'h8000_0110, 4'b0010, TK_TGT, {4{32'h2200_0002}}, 4'b0011, 4'b0010);
    // Credits 14,12 then 8,4,0: a group at 0x420 is only possible if the
    // partial groups cost 2 each
    fetch_group(64'h8000_0400, 4'b0, NO_TGT, {4{32'h2200_0003}}, 4'b1111, 4'b0);
    fetch_group(64'h8000_0410, 4'b0, NO_TGT, {4{32'h2200_0004}}, 4'b1111, 4'b0);
    fetch_group(64'h8000_0420, 4'b0, NO_TGT, {4{32'h2200_0005}}, 4'b1111, 4'b0);
    repeat (2) begin
      @(posedge clock); #1;
      check("credits_exhausted", 128'(fetch_req_valid), 128'(0));
    end

    // Redirect refills credits; second redirect while waiting drains
    redirect_valid = 1'b1;
    redirect_target = 64'h8000_1000;
    @(posedge clock); #1;
    redirect_valid = 1'b0;
    req_q.push_back(64'h8000_1000);
    accept_req();
    redirect_valid = 1'b1;
    redirect_target = 64'h8000_2000;
    @(posedge clock); #1;
    redirect_valid = 1'b0;
    repeat (3) begin
      check("drain_no_req", 128'(fetch_req_valid), 128'(0));
      check("drain_busy",   128'(busy),            128'(1));
      @(posedge clock); #1;
    end
    fetch_resp_valid = 1'b1;
    fetch_resp_instr = {4{32'hDEAD_BEEF}};
    @(posedge clock); #1;
    fetch_resp_valid = 1'b0;
    check("drain_drop_ib",   128'(ib_instr_valid), 128'(0));
    check("drain_req_valid", 128'(fetch_req_valid), 128'(1));
    check("drain_req_pc",    128'(fetch_req_pc),    128'(64'h8000_2000));
    @(posedge clock); #1;
    check("drain_drop_ib2",  128'(ib_instr_valid), 128'(0));
    fetch_group(64'h8000_2000, 4'b0, NO_TGT, {4{32'h3300_0001}}, 4'b1111, 4'b0);

    // Redirect coinciding with the response
    req_q.push_back(64'h8000_2010);
    accept_req();
    fetch_resp_valid = 1'b1;
    fetch_resp_instr = {4{32'hBAD0_0001}};
    redirect_valid = 1'b1;
    redirect_target = 64'h8000_3004;
    @(posedge clock); #1;
    fetch_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    check("same_cycle_req_valid", 128'(fetch_req_valid), 128'(1));
    check("same_cycle_req_pc",    128'(fetch_req_pc),    128'(64'h8000_3004));
    check("same_cycle_ib_drop",   128'(ib_instr_valid),  128'(0));
    fetch_group(64'h8000_3004, 4'b0, NO_TGT, {4{32'h4400_0001}}, 4'b1110, 4'b0);

    // Arbiter stall: request must hold steady
    wait_req(20);
    repeat (5) begin
      check("stall_valid", 128'(fetch_req_valid), 128'(1));
      check("stall_pc",    128'(fetch_req_pc),    128'(64'h8000_3010));
      check("stall_busy",  128'(busy),            128'(1));
      @(posedge clock); #1;
    end

    // Asynchronous reset mid-hold
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    fetch_group(64'h8000_0000, 4'b0, NO_TGT, {4{32'h5500_0001}}, 4'b1111, 4'b0);

    repeat (3) @(posedge clock);
    #1;
    check("req_queue_empty", 128'(req_q.size()), 128'(0));
    check("ib_queue_empty",  128'(ib_q.size()),  128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
